// File: rtl/mmio_input_port.sv
// mmio_input_port: debounced KEY/SW inputs with sticky press/release flags and press counters on the CPU data bus.
// Latency: rdata 1 cycle after the access; raw input edge to stable value 2+DEBOUNCE_CYCLES cycles.
// Backpressure: none, every access completes in one cycle. Define MMIO_INPUT_IRQ_EN for the irq output and IRQ_MASK register.
module mmio_input_port #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned N_SW            = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    input  logic [N_SW-1:0]   sw,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    output logic [31:0]       rdata,
    output logic              hit
`ifdef MMIO_INPUT_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int unsigned N_IN = N_KEYS + N_SW;
    localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0]   raw_in;
    logic [N_IN-1:0]   sync1_q, sync2_q;
    logic [N_IN-1:0]   stable_q;
    logic [CW-1:0]     db_cnt_q [N_IN];
    logic [N_IN-1:0]   accept;

    logic [N_KEYS-1:0] evt_press_q, evt_press_d;
    logic [N_KEYS-1:0] evt_rel_q, evt_rel_d;
    logic [7:0]        press_cnt_q [N_KEYS];
    logic [7:0]        press_cnt_d [N_KEYS];
    logic [N_KEYS-1:0] press_det, rel_det;
    logic [31:0]       rdata_q, rdata_d, rd_val;

    logic [1:0]        offset;
    logic              wr_en, rd_en, evt_clr_en, cnt_clr_en;
    logic              unused_ok;

    // Keys are inverted ahead of the synchroniser so a freshly reset flop already reads "released".
    assign raw_in    = {sw, ~key_n};
    assign unused_ok = ^{addr[1:0], wdata[31:8]};

    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            accept[i] = (sync2_q[i] != stable_q[i]) && (db_cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            for (int i = 0; i < int'(N_IN); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_q ^ accept;
            for (int i = 0; i < int'(N_IN); i++) begin
                if ((sync2_q[i] == stable_q[i]) || accept[i]) begin
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset = addr[3:2];
    assign wr_en  = hit && we;
    assign rd_en  = hit && !we;

`ifdef MMIO_INPUT_IRQ_EN
    logic [N_KEYS-1:0] irq_mask_q, irq_mask_d;
    logic              irq_q;

    assign irq_mask_d = (wr_en && (offset == 2'd3)) ? wdata[N_KEYS-1:0] : irq_mask_q;
    assign irq        = irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= |(evt_press_q & irq_mask_q);
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        case (offset)
            2'd0: begin
                rd_val[N_SW-1:0]     = stable_q[N_IN-1:N_KEYS];
                rd_val[16 +: N_KEYS] = stable_q[N_KEYS-1:0];
            end
            2'd1: rd_val[2*N_KEYS-1:0] = {evt_rel_q, evt_press_q};
            2'd2: begin
                for (int k = 0; k < int'(N_KEYS); k++) begin
                    rd_val[8*k +: 8] = press_cnt_q[k];
                end
            end
            default: begin
`ifdef MMIO_INPUT_IRQ_EN
                rd_val[N_KEYS-1:0] = irq_mask_q;
`endif
            end
        endcase
    end

    // A new event in the same cycle as its clear wins, so edges are never lost.
    always_comb begin
        press_det   = accept[N_KEYS-1:0] & sync2_q[N_KEYS-1:0];
        rel_det     = accept[N_KEYS-1:0] & ~sync2_q[N_KEYS-1:0];
        evt_clr_en  = wr_en && (offset == 2'd1);
        cnt_clr_en  = wr_en && (offset == 2'd2);
        evt_press_d = (evt_press_q & ~(evt_clr_en ? wdata[N_KEYS-1:0] : '0)) | press_det;
        evt_rel_d   = (evt_rel_q & ~(evt_clr_en ? wdata[N_KEYS +: N_KEYS] : '0)) | rel_det;
        for (int k = 0; k < int'(N_KEYS); k++) begin
            press_cnt_d[k] = (cnt_clr_en ? 8'd0 : press_cnt_q[k]) + {7'd0, press_det[k]};
        end
        rdata_d = rd_en ? rd_val : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_press_q <= '0;
            evt_rel_q   <= '0;
            rdata_q     <= '0;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                press_cnt_q[k] <= '0;
            end
        end else begin
            evt_press_q <= evt_press_d;
            evt_rel_q   <= evt_rel_d;
            rdata_q     <= rdata_d;
            for (int k = 0; k < int'(N_KEYS); k++) begin
                press_cnt_q[k] <= press_cnt_d[k];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_input_port.sv
// Randomised and directed bench for mmio_input_port with a window-based reference model and a per-cycle scoreboard.
module tb_mmio_input_port;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic [9:0]  sw = 10'h3FF;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq_w;

    mmio_input_port #(
        .BASE_ADDR(32'h0000_1000),
        .DEBOUNCE_CYCLES(D),
        .N_KEYS(4),
        .N_SW(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_n(key_n),
        .sw(sw),
        .addr(addr),
        .wdata(wdata),
        .we(we),
        .rdata(rdata),
        .hit(hit)
`ifdef MMIO_INPUT_IRQ_EN
        ,
        .irq(irq_w)
`endif
    );

`ifndef MMIO_INPUT_IRQ_EN
    assign irq_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rd;
        logic        h;
        logic        irq;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] hist[$];      // raw samples, newest first, keys in pressed=1 form
    logic [13:0] m_st;         // [3:0] keys, [13:4] switches
    logic [3:0]  m_press, m_rel, m_mask, pev, rev;
    int          m_cnt[4];
    exp_t        e;
    bit          flip;

    function automatic logic [31:0] reg_read(input logic [1:0] off);
        logic [31:0] v;
        v = 32'd0;
        if (off == 2'd0) v = {12'd0, m_st[3:0], 6'd0, m_st[13:4]};
        else if (off == 2'd1) v = {24'd0, m_rel, m_press};
        else if (off == 2'd2) v = (m_cnt[3] << 24) | (m_cnt[2] << 16) | (m_cnt[1] << 8) | m_cnt[0];
`ifdef MMIO_INPUT_IRQ_EN
        else v = {28'd0, m_mask};
`endif
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            hist.delete();
            for (int j = 0; j < D + 2; j++) hist.push_back(14'd0);
            m_st = '0; m_press = '0; m_rel = '0; m_mask = '0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            exp_q.delete();
        end else begin
            e.h   = (addr[31:4] == 28'h0000_100);
            e.rd  = (e.h && !we) ? reg_read(addr[3:2]) : 32'd0;
            e.irq = |(m_press & m_mask);
            exp_q.push_back(e);
            // An input is accepted once the synchronised value (raw from two edges ago)
            // has disagreed with the stable value for D consecutive edges.
            hist.push_front({sw, ~key_n});
            void'(hist.pop_back());
            pev = '0; rev = '0;
            for (int i = 0; i < 14; i++) begin
                flip = 1'b1;
                for (int j = 2; j < D + 2; j++) if (hist[j][i] == m_st[i]) flip = 1'b0;
                if (flip) begin
                    m_st[i] = ~m_st[i];
                    if (i < 4) begin
                        if (m_st[i]) pev[i] = 1'b1;
                        else rev[i] = 1'b1;
                    end
                end
            end
            if (e.h && we && addr[3:2] == 2'd1) begin
                m_press = m_press & ~wdata[3:0];
                m_rel   = m_rel & ~wdata[7:4];
            end
            if (e.h && we && addr[3:2] == 2'd2) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
`ifdef MMIO_INPUT_IRQ_EN
            if (e.h && we && addr[3:2] == 2'd3) m_mask = wdata[3:0];
`endif
            m_press = m_press | pev;
            m_rel   = m_rel | rev;
            for (int k = 0; k < 4; k++) if (pev[k]) m_cnt[k] = (m_cnt[k] + 1) % 256;
        end
    end

    // ---------------- monitor ----------------
    exp_t got;
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rdata_in_reset", rdata, 32'd0);
        end else if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("rdata", rdata, got.rd);
            chk("hit", {31'd0, hit}, {31'd0, got.h});
`ifdef MMIO_INPUT_IRQ_EN
            chk("irq", {31'd0, irq_w}, {31'd0, got.irq});
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk); #1;
        addr = a; we = w; wdata = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("rdata_async_reset", rdata, 32'd0);
        chk("irq_async_reset", {31'd0, irq_w}, 32'd0);
        repeat (n) @(negedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b1;
        idle(10);
        step(32'h1000, 1'b0, 0);
        step(32'h1004, 1'b0, 0);
        idle(2);

        // key 1 press with bounces
        key_n[1] = 1'b0; idle(2);
        key_n[1] = 1'b1; idle(2);
        key_n[1] = 1'b0; idle(12);
        step(32'h1004, 1'b0, 0);
        step(32'h1008, 1'b0, 0);
        key_n[1] = 1'b1; idle(10);
        step(32'h1004, 1'b1, 32'h2);
        step(32'h1004, 1'b0, 0);
        step(32'h1004, 1'b1, 32'h20);
        step(32'h1006, 1'b0, 0);
        idle(2);

        // W1C / PRESS_CNT write landing on the detection cycle, swept around it
        for (int off = 3; off <= 7; off++) begin
            idle(1); key_n[0] = 1'b0;
            idle(off);
            step(32'h1004, 1'b1, 32'h1);
            idle(6);
            step(32'h1004, 1'b0, 0);
            key_n[0] = 1'b1; idle(8);
            step(32'h1004, 1'b1, 32'hFF);
            idle(1); key_n[2] = 1'b0;
            idle(off);
            step(32'h1008, 1'b1, 32'h0);
            idle(6);
            step(32'h1008, 1'b0, 0);
            key_n[2] = 1'b1; idle(8);
        end

        // 256 presses on key 3 wrap the counter
        step(32'h1008, 1'b1, 0);
        for (int n = 0; n < 256; n++) begin
            key_n[3] = 1'b0; idle(7);
            key_n[3] = 1'b1; idle(7);
        end
        step(32'h1008, 1'b0, 0);
        step(32'h1004, 1'b0, 0);
        step(32'h1008, 1'b1, 32'hDEAD);
        step(32'h1008, 1'b0, 0);

        // out-of-window and read-only accesses
        step(32'h2004, 1'b1, 32'hFFFF_FFFF);
        step(32'h2004, 1'b0, 0);
        step(32'h2008, 1'b1, 32'hFFFF_FFFF);
        step(32'h1000, 1'b1, 32'hFFFF_FFFF);
        step(32'h1000, 1'b0, 0);
        step(32'h1004, 1'b0, 0);
        step(32'h100C, 1'b0, 0);
        idle(1);

        // reset in the middle of a debounce with key 2 held
        key_n[2] = 1'b0; idle(3);
        do_reset(3);
        idle(12);
        step(32'h1004, 1'b0, 0);
        step(32'h1008, 1'b0, 0);
        key_n[2] = 1'b1; idle(10);
        step(32'h1004, 1'b1, 32'hFF);

`ifdef MMIO_INPUT_IRQ_EN
        step(32'h100C, 1'b1, 32'h1);
        step(32'h100C, 1'b0, 0);
        key_n[0] = 1'b0; idle(10);
        step(32'h1004, 1'b1, 32'h1);
        idle(3);
        key_n[0] = 1'b1; idle(10);
        step(32'h1004, 1'b1, 32'hFF);
`endif

        // randomised traffic
        for (int c = 0; c < 2000; c++) begin
            int op;
            op = int'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) key_n[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) sw = 10'($urandom);
            if (op < 5) step(32'h1000 | $urandom_range(0, 15), 1'b0, 0);
            else if (op == 5) step(32'h1000 | $urandom_range(0, 15), 1'b1, $urandom);
            else if (op == 6) step($urandom, $urandom_range(0, 1) == 1, $urandom);
            else idle(1);
        end
        key_n = 4'hF;
        idle(12);
        for (int r = 0; r < 4; r++) step(32'h1000 + 4 * r, 1'b0, 0);
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
